fir_filter_core: RTL

- Sequential multiply-accumulate FIR filter between the I2S controller ADC output (adcData/adcDataValid) and its DAC input (dacData/dacDataValid).
- Coefficients are loaded serially from the config store's serial output (shared serialEn strobe from the SPI slave).
- Uses a single multiplier, one tap per clock.
- Reset coefficients give exact unity pass-through.

---
 rtl/fir_filter_core.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fir_filter_core.sv
// ---------------------------------------------------------------------------
// fir_filter_core
//
// Sequential multiply-accumulate FIR filter. It sits between the I2S ADC
// output and the DAC input. One multiplier is shared across all taps, and one
// tap is processed per clock. Coefficients arrive over a serial load chain that
// is fed from the config store. The chain is committed to the active
// coefficient bank only while the filter is idle, so a sample is never
// computed with a mix of old and new coefficients.
//
// Optional feature (compile-time macro):
//   FIR_SATURATE_EN  defined   : output clamps to [-2^(DataWidth-1), 2^(DataWidth-1)-1]
//                    undefined : output keeps the low DataWidth bits (wraps)
//
// Ports:
//   clk             in   system clock
//   reset           in   asynchronous active-low reset
//   serialEn        in   serial shift enable, high for a whole SPI frame
//   serialIn        in   coefficient bit, valid while serialEn=1
//   sampleIn        in   [DataWidth] signed ADC sample
//   sampleInValid   in   one-cycle strobe qualifying sampleIn
//   sampleOut       out  [DataWidth] filtered sample, held between strobes
//   sampleOutValid  out  one-cycle strobe qualifying sampleOut
//   busy            out  high while a sample is being processed
// ---------------------------------------------------------------------------
module fir_filter_core #(
  parameter int DataWidth  = 12,
  parameter int CoeffWidth = 12,
  parameter int NumTaps    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serialEn,
  input  logic                 serialIn,
  input  logic [DataWidth-1:0] sampleIn,
  input  logic                 sampleInValid,
  output logic [DataWidth-1:0] sampleOut,
  output logic                 sampleOutValid,
  output logic                 busy
);

  localparam int AccWidth  = DataWidth + CoeffWidth + $clog2(NumTaps);
  localparam int ProdWidth = DataWidth + CoeffWidth;
  localparam int ChainW    = NumTaps * CoeffWidth;
  localparam int CntW      = $clog2(NumTaps);
  // Q2.(CoeffWidth-2): drop the fractional coefficient bits on output
  localparam int FracBits  = CoeffWidth - 2;
  localparam logic [CoeffWidth-1:0] CoeffOne = CoeffWidth'(1 << FracBits);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                                 state_q;
  logic [CntW-1:0]                        cnt_q;
  logic signed [AccWidth-1:0]             acc_q;
  logic [NumTaps-1:0][DataWidth-1:0]      dline_q;   // dline_q[0] = newest
  logic [NumTaps-1:0][CoeffWidth-1:0]     coef_q;    // active coefficients
  logic [ChainW-1:0]                      chain_q, chain_d;
  logic                                   ser_en_q;
  logic                                   pend_q, pend_d;
  logic [DataWidth-1:0]                   out_q, out_d;
  logic                                   vld_q;
  logic                                   busy_q;

  // ---------------------------------------------------------------------
  // Serial coefficient load chain and commit tracking
  // ---------------------------------------------------------------------
  // The first bit shifted in ends up as the MSB of the top tap. Overlong
  // frames push their earliest bits out of the top of the chain.
  always_comb begin
    chain_d = chain_q;
    if (serialEn) chain_d = {chain_q[ChainW-2:0], serialIn};
  end

  // The commit waits for an idle cycle. The falling edge of serialEn only
  // marks the chain as ready to be copied.
  logic commit;
  assign commit = pend_q && (state_q == S_IDLE);

  always_comb begin
    pend_d = pend_q;
    if (commit)                 pend_d = 1'b0;
    if (ser_en_q && !serialEn)  pend_d = 1'b1;
  end

  // ---------------------------------------------------------------------
  // MAC datapath: single shared multiplier indexed by the tap counter
  // ---------------------------------------------------------------------
  logic signed [DataWidth-1:0]  x_w;
  logic signed [CoeffWidth-1:0] c_w;
  logic signed [ProdWidth-1:0]  prod_w;
  logic signed [AccWidth-1:0]   prod_ext;

  assign x_w      = dline_q[cnt_q];
  assign c_w      = coef_q[cnt_q];
  assign prod_w   = x_w * c_w;
  assign prod_ext = {{(AccWidth-ProdWidth){prod_w[ProdWidth-1]}}, prod_w};

  // ---------------------------------------------------------------------
  // Output scaling: arithmetic floor shift, then clamp or wrap
  // ---------------------------------------------------------------------
`ifdef FIR_SATURATE_EN
  localparam logic signed [AccWidth-1:0] SatMax = AccWidth'((1 << (DataWidth-1)) - 1);
  localparam logic signed [AccWidth-1:0] SatMin = -SatMax - AccWidth'(1);

  logic signed [AccWidth-1:0] shifted_w;
  assign shifted_w = acc_q >>> FracBits;

  always_comb begin
    out_d = shifted_w[DataWidth-1:0];
    if (shifted_w > SatMax)      out_d = SatMax[DataWidth-1:0];
    else if (shifted_w < SatMin) out_d = SatMin[DataWidth-1:0];
  end
`else
  // The low DataWidth bits of the floor-shifted value are just a bit slice.
  always_comb begin
    out_d = acc_q[FracBits +: DataWidth];
  end
`endif

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      dline_q  <= '0;
      coef_q   <= '0;
      coef_q[0] <= CoeffOne;       // unity pass-through
      chain_q  <= '0;
      ser_en_q <= 1'b0;
      pend_q   <= 1'b0;
      out_q    <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ser_en_q <= serialEn;
      chain_q  <= chain_d;
      pend_q   <= pend_d;
      vld_q    <= 1'b0;

      // The commit happens before a sample that is accepted in the same
      // cycle starts its MAC, so that sample already uses the new set.
      if (commit) coef_q <= chain_q;

      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (sampleInValid) begin
            dline_q <= {dline_q[NumTaps-2:0], sampleIn};
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_MAC;
          end
        end

        // Strobes that arrive in S_MAC or S_OUT are ignored (overrun drop).
        S_MAC: begin
          acc_q <= acc_q + prod_ext;
          if (cnt_q == CntW'(NumTaps-1)) state_q <= S_OUT;
          else                           cnt_q   <= cnt_q + 1'b1;
        end

        S_OUT: begin
          out_q   <= out_d;
          vld_q   <= 1'b1;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sampleOut      = out_q;
  assign sampleOutValid = vld_q;
  assign busy           = busy_q;

endmodule
